// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file.
// Selects the write-back value, applies conditional-move gating, commits to
// the register array, serves two bypassed read ports and counts commits.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WB_RegWrite,
    input  logic              WB_CondMov,
    input  logic              WB_ZeroFlag,
    input  logic              WB_MemtoReg,
    input  logic [DATA_W-1:0] WB_ALUResult,
    input  logic [DATA_W-1:0] WB_DMResult,
    input  logic [ADDR_W-1:0] WB_WriteRegister,
    input  logic [ADDR_W-1:0] ID_ReadRegister1,
    input  logic [ADDR_W-1:0] ID_ReadRegister2,
    output logic [DATA_W-1:0] ID_ReadData1,
    output logic [DATA_W-1:0] ID_ReadData2,
    output logic [DATA_W-1:0] WB_WriteData,
    output logic              WB_WriteEnable,
    output logic [CNT_W-1:0]  WriteCount
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    // Write-back value selection and effective commit strobe
    always_comb begin
        WB_WriteData   = WB_MemtoReg ? WB_DMResult : WB_ALUResult;
        WB_WriteEnable = !Reset && WB_RegWrite && (!WB_CondMov || WB_ZeroFlag)
                         && (WB_WriteRegister != '0);
    end

    // Register 0 is hardwired to zero; otherwise a same-cycle commit to the
    // addressed register is bypassed ahead of the array contents.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] val;
        val = '0;
        if (idx == '0)
            val = '0;
        else if (WB_WriteEnable && (idx == WB_WriteRegister))
            val = WB_WriteData;
        else
            val = regs[idx];
        return val;
    endfunction

    // Both read ports resolve independently
    always_comb begin
        ID_ReadData1 = read_port(ID_ReadRegister1);
        ID_ReadData2 = read_port(ID_ReadRegister2);
    end

    // Commit, counter and synchronous clear (reset discards any pending write)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[ADDR_W'(i)] <= '0;
            WriteCount <= '0;
        end else if (WB_WriteEnable) begin
            regs[WB_WriteRegister] <= WB_WriteData;
            WriteCount             <= WriteCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expected output values,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile;

    localparam int K_RD1 = 0;
    localparam int K_RD2 = 1;
    localparam int K_WD  = 2;
    localparam int K_WE  = 3;
    localparam int K_CNT = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        WB_RegWrite, WB_CondMov, WB_ZeroFlag, WB_MemtoReg;
    logic [31:0] WB_ALUResult, WB_DMResult;
    logic [4:0]  WB_WriteRegister, ID_ReadRegister1, ID_ReadRegister2;
    logic [31:0] ID_ReadData1, ID_ReadData2, WB_WriteData;
    logic        WB_WriteEnable;
    logic [31:0] WriteCount;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .WB_RegWrite      (WB_RegWrite),
        .WB_CondMov       (WB_CondMov),
        .WB_ZeroFlag      (WB_ZeroFlag),
        .WB_MemtoReg      (WB_MemtoReg),
        .WB_ALUResult     (WB_ALUResult),
        .WB_DMResult      (WB_DMResult),
        .WB_WriteRegister (WB_WriteRegister),
        .ID_ReadRegister1 (ID_ReadRegister1),
        .ID_ReadRegister2 (ID_ReadRegister2),
        .ID_ReadData1     (ID_ReadData1),
        .ID_ReadData2     (ID_ReadData2),
        .WB_WriteData     (WB_WriteData),
        .WB_WriteEnable   (WB_WriteEnable),
        .WriteCount       (WriteCount)
    );

    always #5 Clk = ~Clk;

    // Monitor: every negedge, check all expectations queued for this cycle
    always @(negedge Clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_RD1:   act = ID_ReadData1;
                K_RD2:   act = ID_ReadData2;
                K_WD:    act = WB_WriteData;
                K_WE:    act = {31'd0, WB_WriteEnable};
                default: act = WriteCount;
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_out(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic rw, input logic cm, input logic zf,
                         input logic m2r, input logic [31:0] alu, input logic [31:0] dm,
                         input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
        Reset            = rst;
        WB_RegWrite      = rw;
        WB_CondMov       = cm;
        WB_ZeroFlag      = zf;
        WB_MemtoReg      = m2r;
        WB_ALUResult     = alu;
        WB_DMResult      = dm;
        WB_WriteRegister = wr;
        ID_ReadRegister1 = r1;
        ID_ReadRegister2 = r2;
    endtask

    task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, r1, r2);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        expect_out(K_CNT, 32'd0, "reset_count");
        expect_out(K_WE, 32'd0, "reset_we");

        // All 32 indices read zero after reset
        for (int i = 0; i < 16; i++) begin
            idle_read(5'(i), 5'(31 - i));
            expect_out(K_RD1, 32'd0, "reset_read1");
            expect_out(K_RD2, 32'd0, "reset_read2");
            step();
        end
        expect_out(K_CNT, 32'd0, "count_after_reads");

        // ALU write to r8 with same-cycle bypass on port 1
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 5'd8, 5'd8, 5'd0);
        expect_out(K_RD1, 32'h1234_5678, "bypass_r8");
        expect_out(K_WE, 32'd1, "we_r8");
        expect_out(K_RD2, 32'd0, "r0_during_write");
        step();
        idle_read(5'd8, 5'd0);
        expect_out(K_RD1, 32'h1234_5678, "commit_r8");
        expect_out(K_CNT, 32'd1, "count_1");
        step();

        // Load result selected via MemtoReg into r9, bypass on port 2
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF, 5'd9, 5'd8, 5'd9);
        expect_out(K_WD, 32'hDEAD_BEEF, "wdata_mem");
        expect_out(K_RD2, 32'hDEAD_BEEF, "bypass_r9");
        expect_out(K_RD1, 32'h1234_5678, "r8_no_bypass");
        step();
        idle_read(5'd8, 5'd9);
        expect_out(K_RD2, 32'hDEAD_BEEF, "commit_r9");
        expect_out(K_CNT, 32'd2, "count_2");
        step();

        // Conditional move, condition false: no write
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'h0, 5'd10, 5'd10, 5'd0);
        expect_out(K_WE, 32'd0, "condmov_false_we");
        expect_out(K_RD1, 32'd0, "condmov_false_nobypass");
        step();
        idle_read(5'd10, 5'd0);
        expect_out(K_RD1, 32'd0, "condmov_false_r10");
        expect_out(K_CNT, 32'd2, "condmov_false_count");
        step();

        // Conditional move, condition true: write happens
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd5, 32'h0, 5'd10, 5'd10, 5'd0);
        expect_out(K_WE, 32'd1, "condmov_true_we");
        expect_out(K_RD1, 32'd5, "condmov_true_bypass");
        step();
        idle_read(5'd10, 5'd0);
        expect_out(K_RD1, 32'd5, "condmov_true_r10");
        expect_out(K_CNT, 32'd3, "condmov_true_count");
        step();

        // Write to r0 is dropped and not counted
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_out(K_WE, 32'd0, "r0_we");
        expect_out(K_WD, 32'hFFFF_FFFF, "r0_wdata");
        expect_out(K_RD1, 32'd0, "r0_read1");
        expect_out(K_RD2, 32'd0, "r0_read2");
        step();
        idle_read(5'd0, 5'd0);
        expect_out(K_RD1, 32'd0, "r0_after_read1");
        expect_out(K_CNT, 32'd3, "r0_count");
        step();

        // Both ports hit the bypass in the same cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A, 32'h0, 5'd12, 5'd12, 5'd12);
        expect_out(K_RD1, 32'hA5A5_5A5A, "dual_bypass1");
        expect_out(K_RD2, 32'hA5A5_5A5A, "dual_bypass2");
        step();

        // CondMov with RegWrite low never writes
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0077, 32'h0, 5'd13, 5'd13, 5'd12);
        expect_out(K_WE, 32'd0, "condmov_norw_we");
        expect_out(K_RD1, 32'd0, "condmov_norw_r13");
        expect_out(K_RD2, 32'hA5A5_5A5A, "commit_r12");
        expect_out(K_CNT, 32'd4, "count_4");
        step();

        // Fill r8 = 7
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'h0, 5'd8, 5'd0, 5'd0);
        step();
        idle_read(5'd8, 5'd0);
        expect_out(K_RD1, 32'd7, "r8_is_7");
        expect_out(K_CNT, 32'd5, "count_5");
        step();

        // Reset with a pending write: write lost, bypass disabled
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'h0, 5'd11, 5'd11, 5'd8);
        expect_out(K_WE, 32'd0, "reset_cycle_we");
        expect_out(K_RD1, 32'd0, "reset_cycle_nobypass");
        expect_out(K_RD2, 32'd7, "reset_cycle_array_r8");
        step();
        idle_read(5'd8, 5'd11);
        expect_out(K_RD1, 32'd0, "post_reset_r8");
        expect_out(K_RD2, 32'd0, "post_reset_r11");
        expect_out(K_CNT, 32'd0, "post_reset_count");
        step();

        // Writes resume on the first edge after reset deasserts
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'h0, 5'd11, 5'd0, 5'd0);
        expect_out(K_WE, 32'd1, "resume_we");
        step();
        idle_read(5'd11, 5'd0);
        expect_out(K_RD1, 32'd3, "resume_r11");
        expect_out(K_CNT, 32'd1, "resume_count");
        step();

        step();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
